// File: rtl/adder_chunked_nbit_if.sv
// Handshake and operand bundle for the chunked adder.
// master drives operands and accepts results.
interface adder_chunked_nbit_if #(
  parameter int N = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         carry_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         carry_out;
  logic         overflow;

  modport master (
    output in_valid, a, b, carry_in, sub, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow
  );

  modport slave (
    input  in_valid, a, b, carry_in, sub, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow
  );
endinterface

// File: rtl/adder_chunked_nbit.sv
// Multi-cycle N-bit add/sub, one W-bit slice per clock,
// carry rippled through a register between slices.
module adder_chunked_nbit #(
  parameter int N = 16,
  parameter int W = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  adder_chunked_nbit_if.slave  bus
);
  localparam int CHUNKS = (N + W - 1) / W;
  localparam int L      = N - (CHUNKS - 1) * W;
  localparam int KW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  logic [N-1:0]   sum_q;
  logic           c_q;
  logic           co_q;
  logic           ov_q;
  logic [KW-1:0]  k_q;

  int             sh;
  logic [W-1:0]   a_sl;
  logic [W-1:0]   b_sl;
  logic [W:0]     s;
  logic [N-1:0]   wmask;
  logic [N-1:0]   wdata;
  logic           last;
  logic           co_last;
  logic           ci_last;

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.carry_out = co_q;
  assign bus.overflow  = ov_q;

  // Current slice: operand bits, W-bit add, write mask
  always_comb begin
    sh      = int'(k_q) * W;
    a_sl    = W'(a_q >> sh);
    b_sl    = W'(b_q >> sh);
    s       = {1'b0, a_sl} + {1'b0, b_sl} + {{W{1'b0}}, c_q};
    wmask   = N'({W{1'b1}}) << sh;
    wdata   = N'(s[W-1:0]) << sh;
    last    = (k_q == KW'(CHUNKS - 1));
    co_last = s[L];
    ci_last = a_sl[L-1] ^ b_sl[L-1] ^ s[L-1];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.in_valid) state_d = RUN;
      RUN:  if (last) state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture and per-slice accumulate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      c_q   <= 1'b0;
      co_q  <= 1'b0;
      ov_q  <= 1'b0;
      k_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q <= bus.a;
            b_q <= bus.sub ? ~bus.b : bus.b;
            c_q <= bus.sub ? 1'b1 : bus.carry_in;
            k_q <= '0;
          end
        end
        RUN: begin
          sum_q <= (sum_q & ~wmask) | (wdata & wmask);
          c_q   <= s[W];
          k_q   <= k_q + KW'(1);
          if (last) begin
            co_q <= co_last;
            ov_q <= co_last ^ ci_last;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_chunked_nbit.sv
// Directed bench for adder_chunked_nbit at N=16/W=8 and N=34/W=8.
// Expected results are queued at drive time and popped on out_valid.
module tb_adder_chunked_nbit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adder_chunked_nbit_if #(.N(16)) if16 ();
  adder_chunked_nbit_if #(.N(34)) if34 ();

  adder_chunked_nbit #(.N(16), .W(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(if16.slave)
  );
  adder_chunked_nbit #(.N(34), .W(8)) dut34 (
    .clk(clk), .rst_n(rst_n), .bus(if34.slave)
  );

  int          sel = 0;
  logic        vld = 1'b0;
  logic        rdy = 1'b0;
  logic [33:0] a_in = '0;
  logic [33:0] b_in = '0;
  logic        cin_in = 1'b0;
  logic        sub_in = 1'b0;

  assign if16.in_valid  = vld & (sel == 0);
  assign if34.in_valid  = vld & (sel == 1);
  assign if16.out_ready = rdy & (sel == 0);
  assign if34.out_ready = rdy & (sel == 1);
  assign if16.a = a_in[15:0];
  assign if16.b = b_in[15:0];
  assign if34.a = a_in;
  assign if34.b = b_in;
  assign if16.carry_in = cin_in;
  assign if34.carry_in = cin_in;
  assign if16.sub = sub_in;
  assign if34.sub = sub_in;

  logic        o_valid;
  logic        o_ready;
  logic [33:0] o_sum;
  logic        o_co;
  logic        o_ov;
  assign o_valid = sel ? if34.out_valid : if16.out_valid;
  assign o_ready = sel ? if34.in_ready : if16.in_ready;
  assign o_sum   = sel ? if34.sum : {18'b0, if16.sum};
  assign o_co    = sel ? if34.carry_out : if16.carry_out;
  assign o_ov    = sel ? if34.overflow : if16.overflow;

  typedef struct {
    logic [33:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail = 0;

  function automatic exp_t model(input int n, input logic [33:0] a,
                                 input logic [33:0] b, input logic cin,
                                 input logic sb);
    exp_t e;
    logic [34:0] m, aa, bb, full;
    m    = (35'd1 << n) - 35'd1;
    aa   = {1'b0, a} & m;
    bb   = sb ? (~{1'b0, b}) & m : {1'b0, b} & m;
    full = aa + bb + {34'b0, (sb ? 1'b1 : cin)};
    e.s  = 34'(full & m);
    e.co = full[n];
    e.ov = (aa[n-1] == bb[n-1]) && (full[n-1] != aa[n-1]);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [33:0] obs,
                     input logic [33:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_in_ready"}, 34'(o_ready), 34'd1);
    chk({tag, "_out_valid"}, 34'(o_valid), 34'd0);
    chk({tag, "_sum"}, o_sum, 34'd0);
    chk({tag, "_co"}, 34'(o_co), 34'd0);
    chk({tag, "_ov"}, 34'(o_ov), 34'd0);
  endtask

  task automatic xact(input int s, input logic [33:0] a,
                      input logic [33:0] b, input logic cin,
                      input logic sb, input int hold);
    exp_t e;
    int   cyc;
    bit   got;
    sel = s;
    @(negedge clk);
    a_in = a; b_in = b; cin_in = cin; sub_in = sb; vld = 1'b1;
    q.push_back(model(s ? 34 : 16, a, b, cin, sb));
    @(posedge clk); #1;
    vld = 1'b0;
    chk("busy_in_ready", 34'(o_ready), 34'd0);
    cyc = 0; got = 1'b0;
    while (!got && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      got = o_valid;
    end
    chk("latency", 34'(cyc), s ? 34'd5 : 34'd2);
    e = q.pop_front();
    chk("sum", o_sum, e.s);
    chk("carry_out", 34'(o_co), 34'(e.co));
    chk("overflow", 34'(o_ov), 34'(e.ov));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      a_in = 34'h0_5A5A + 34'(i); b_in = 34'h11; vld = (i % 2 == 0);
      @(posedge clk); #1;
      vld = 1'b0;
      chk("hold_valid", 34'(o_valid), 34'd1);
      chk("hold_in_ready", 34'(o_ready), 34'd0);
      chk("hold_sum", o_sum, e.s);
      chk("hold_co", 34'(o_co), 34'(e.co));
    end
    @(negedge clk);
    rdy = 1'b1;
    @(posedge clk); #1;
    rdy = 1'b0;
    chk("release_valid", 34'(o_valid), 34'd0);
    chk("release_in_ready", 34'(o_ready), 34'd1);
    chk("release_sum_kept", o_sum, e.s);
  endtask

  initial begin
    bit seen;
    #2;
    sel = 0; #1; check_idle("rst16");
    sel = 1; #1; check_idle("rst34");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    xact(0, 34'hFFFF, 34'h0001, 1'b0, 1'b0, 0);
    xact(0, 34'h7FFF, 34'h0001, 1'b0, 1'b0, 0);
    xact(0, 34'd5, 34'd7, 1'b1, 1'b1, 0);
    xact(0, 34'h1234, 34'h0F0F, 1'b1, 1'b0, 0);
    xact(1, 34'h3_FFFF_FFFF, 34'd1, 1'b0, 1'b0, 0);
    xact(1, 34'h1_0000_0000, 34'h1_0000_0000, 1'b0, 1'b0, 0);
    xact(1, 34'd0, 34'd1, 1'b0, 1'b1, 0);
    xact(0, 34'h1234, 34'h4321, 1'b0, 1'b0, 4);
    xact(0, 34'h8000, 34'h8000, 1'b0, 1'b0, 0);
    for (int i = 0; i < 6; i++) begin
      xact(i % 2, {2'($urandom), 32'($urandom)},
           {2'($urandom), 32'($urandom)},
           1'($urandom), 1'($urandom), 0);
    end

    sel = 1;
    @(negedge clk);
    a_in = 34'h2_AAAA_5555; b_in = 34'h1_5555_AAAA;
    cin_in = 1'b0; sub_in = 1'b0; vld = 1'b1;
    @(posedge clk); #1;
    vld = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("abort");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (o_valid) seen = 1'b1;
    end
    chk("abort_no_valid", 34'(seen), 34'd0);
    xact(1, 34'd1, 34'd2, 1'b0, 1'b0, 0);
    chk("queue_empty", 34'(q.size()), 34'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/adder_chunked_nbit.md
Name: adder_chunked_nbit

Overview:
- Parametrised multi-cycle adder/subtractor.
- Splits an N-bit add into CHUNKS = ceil(N/W) slices of W bits and processes one slice per clock, rippling the carry through a register.
- Trades latency for a narrow W-bit carry chain, so wide operands (34 bits and up) close timing.
- Sits wherever the combinational N-bit adder is too slow. Uses a valid/ready handshake on both input and output.

Parameters:
- N, 16, operand and sum width (N >= 1).
- W, 8, slice width processed per cycle (1 <= W <= N). N need not be a multiple of W.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands presented
- in_ready  output  1  block can accept operands
- a  input  N  operand A
- b  input  N  operand B
- carry_in  input  1  carry into bit 0; ignored when sub=1
- sub  input  1  0: A+B+carry_in; 1: A-B, computed as A+~B+1
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- sum  output  N  result, bits N-1:0
- carry_out  output  1  carry out of bit N-1. In sub mode, 1 means no borrow.
- overflow  output  1  signed overflow of the N-bit result

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE.
  - in_ready=1 while in IDLE.
  - out_valid=0, sum=0, carry_out=0, overflow=0.
  - Internal slice counter and carry register are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, the block captures a, b (inverted if sub), the initial carry (sub ? 1 : carry_in) and the sub flag. It then clears the counter k and moves to RUN.
- RUN:
  - in_ready=0.
  - Each cycle adds slice k of A, B and the carry register. It writes the W result bits into sum[k*W +: W], updates the carry register and increments k.
  - Last slice width is N-(CHUNKS-1)*W. Bits at or above N are neither computed nor written.
  - On the edge that processes slice CHUNKS-1:
    - carry_out = carry out of bit N-1.
    - overflow = carry into bit N-1 XOR carry out of bit N-1.
    - The FSM moves to DONE and out_valid=1.
- Latency: with the accept edge as E0, out_valid is visible after edge E0+CHUNKS. Examples: N=16, W=8 gives 2 cycles; N=34, W=8 gives 5 cycles. W=N gives 1 cycle.
- DONE:
  - out_valid=1. sum, carry_out and overflow are held stable until out_ready=1.
  - On the edge with out_ready=1, the FSM goes to IDLE and out_valid=0. sum and flags keep their last values.
  - The next accept needs at least one cycle in IDLE, so the throughput is one result per CHUNKS+2 cycles.
- Inputs are sampled only at the accept edge. Changes to a, b or sub during RUN or DONE have no effect.
- in_valid while in_ready=0 is ignored. The upstream must hold in_valid until it is accepted.
- out_ready while out_valid=0 is ignored.
- Partial sum bits are visible on sum during RUN. They are valid only when out_valid=1.
- If rst_n asserts mid-RUN or in DONE, the operation is aborted: no out_valid pulse, and all outputs return to reset values immediately.

Test Plan:
- N=16, W=8, sub=0, a=16'hFFFF, b=16'h0001, cin=0 -> after 2 cycles, out_valid=1, sum=16'h0000, carry_out=1, overflow=0.
- N=16, W=8, sub=0, a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, carry_out=0, overflow=1.
- N=16, W=8, sub=1, a=5, b=7, cin=1 (must be ignored) -> sum=16'hFFFE, carry_out=0 (borrow), overflow=0.
- N=34, W=8, sub=0, a=34'h3_FFFF_FFFF, b=1 -> after 5 cycles, sum=0 and carry_out=1. Also run a=34'h1_0000_0000, b=34'h1_0000_0000 -> sum=34'h2_0000_0000, carry_out=0, overflow=1.
- Backpressure: hold out_ready=0 for 4 cycles in DONE -> outputs stable and in_ready=0 throughout. Pulse in_valid with new operands during that time -> ignored. Release out_ready -> IDLE next cycle.
- Reset mid-RUN (N=34, after slice 2) -> out_valid never asserts, sum=0, in_ready=1. A subsequent transaction with a=1, b=2 gives sum=3.
